// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO ahead of the UART transmitter: hands bytes to the TX one at a time
// and waits for a full Busy rise/fall handshake before issuing the next one.
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  OVF_CLR,
    input  logic                  Busy,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  TIMEOUT_ERR
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TW    = $clog2(BUSY_TIMEOUT) + 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [TW-1:0]         TO_ONE   = TW'(1);
    localparam logic [TW-1:0]         TO_LIMIT = TW'(BUSY_TIMEOUT);

    // state       | meaning
    // S_IDLE      | waiting for data and Busy low to issue the head byte
    // S_WAIT_BUSY | byte issued, waiting (bounded) for Busy to rise
    // S_WAIT_DONE | transmitter busy, waiting for Busy to fall
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [TW-1:0]         r_to_cnt;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_dv;
    logic                  r_ovf;
    logic                  r_to_err;

    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_ovf_set;
    logic          w_issue;
    logic          w_to_set;
    logic [TW-1:0] w_to_cnt_next;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    // FULL is judged before any pop in the same cycle, so a write to a full FIFO is always dropped
    assign w_wr      = WR_EN & ~w_full;
    assign w_ovf_set = WR_EN & w_full;

    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_to_set      = 1'b0;
        w_to_cnt_next = r_to_cnt;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !Busy) begin
                    w_issue       = 1'b1;
                    w_to_cnt_next = '0;
                    w_state_next  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (Busy) begin
                    w_state_next = S_WAIT_DONE;
                end else begin
                    if (r_to_cnt != '1) begin
                        w_to_cnt_next = r_to_cnt + TO_ONE;
                    end
                    // the issued byte counts as consumed; it is not reissued
                    if (w_to_cnt_next >= TO_LIMIT) begin
                        w_to_set     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!Busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_to_cnt <= '0;
            r_p_data <= '0;
            r_dv     <= 1'b0;
            r_ovf    <= 1'b0;
            r_to_err <= 1'b0;
        end else begin
            r_dv     <= w_issue;
            r_to_cnt <= w_to_cnt_next;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_issue) begin
                r_p_data <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_issue})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (OVF_CLR) begin
                r_ovf <= 1'b0;
            end
            if (w_to_set) begin
                r_to_err <= 1'b1;
            end else if (OVF_CLR) begin
                r_to_err <= 1'b0;
            end
        end
    end

    assign P_DATA      = r_p_data;
    assign Data_Valid  = r_dv;
    assign FULL        = w_full;
    assign EMPTY       = w_empty;
    assign COUNT       = r_count;
    assign OVERFLOW    = r_ovf;
    assign TIMEOUT_ERR = r_to_err;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer that sits directly upstream of the UART transmit FSM/serializer. It accepts bytes from the system side at any rate up to one per clock and stores them in a circular FIFO. It presents one byte at a time to the transmitter as a registered `P_DATA` with a single-cycle `Data_Valid` pulse, and issues the next byte only after the transmitter's `Busy` has risen and fallen again. It also flags overflow and a missing `Busy` response.

## Interface
- `DATA_WIDTH`, 8, width of each stored byte and of `P_DATA`
- `ADDR_WIDTH`, 3, FIFO address width; depth = 2**ADDR_WIDTH (8)
- `BUSY_TIMEOUT`, 4, cycles to wait for `Busy` to rise after a `Data_Valid` pulse
---
- `CLK`  in  1  single clock; all state updates on the rising edge
- `RST`  in  1  asynchronous, active-high reset
- `WR_EN`  in  1  write request; sampled on the rising edge of `CLK`
- `WR_DATA`  in  DATA_WIDTH  byte to write
- `OVF_CLR`  in  1  synchronous clear of `OVERFLOW` and `TIMEOUT_ERR`
- `Busy`  in  1  transmitter busy (driven by the TX FSM)
- `P_DATA`  out  DATA_WIDTH  registered byte to transmitter
- `Data_Valid`  out  1  registered one-cycle issue strobe
- `FULL`  out  1  COUNT == 2**ADDR_WIDTH
- `EMPTY`  out  1  COUNT == 0
- `COUNT`  out  ADDR_WIDTH+1  stored entries, 0..2**ADDR_WIDTH
- `OVERFLOW`  out  1  sticky; a write was dropped because the FIFO was full
- `TIMEOUT_ERR`  out  1  sticky; `Busy` did not rise within `BUSY_TIMEOUT` cycles

## Operation
- Storage: `DEPTH` x `DATA_WIDTH` register array, with write and read pointers of `ADDR_WIDTH` bits that wrap modulo `DEPTH`. `COUNT` is held in a separate register. `FULL` and `EMPTY` are decoded from `COUNT`.
- Write: when `WR_EN`=1 and not `FULL`, store `WR_DATA` at the write pointer and increment the pointer.
- Write while full: when `WR_EN`=1 and `FULL`=1, drop the write and set `OVERFLOW`. Memory, pointers and `COUNT` are unchanged.
- Simultaneous write and pop in one cycle: both take effect and `COUNT` is unchanged.
  - When `FULL`=1, a write in the same cycle as a pop is still dropped, because `FULL` is evaluated before the pop.
- Read FSM states:
  - IDLE: if not `EMPTY` and `Busy`=0, then on the next edge load `P_DATA` with the head entry, set `Data_Valid`=1, advance the read pointer, decrement `COUNT`, clear the timeout counter, and go to WAIT_BUSY. Otherwise stay in IDLE.
  - WAIT_BUSY: `Data_Valid`=0 in this state.
    - If `Busy`=1, go to WAIT_DONE.
    - Otherwise increment the timeout counter. When it reaches `BUSY_TIMEOUT`, set `TIMEOUT_ERR` and go to IDLE. The byte is considered consumed and is not reissued.
  - WAIT_DONE: if `Busy`=0, go to IDLE.
- `P_DATA` holds its value from the issue edge until the next issue.
- `OVF_CLR`=1 clears both sticky flags on the next edge. If a set condition occurs in the same cycle, the set wins.
- Timeout counter width: clog2(`BUSY_TIMEOUT`)+1 bits, computed as a constant in RTL. The counter saturates and does not wrap.

## Timing
- Reset values: `P_DATA`=0, `Data_Valid`=0, `FULL`=0, `EMPTY`=1, `COUNT`=0, `OVERFLOW`=0, `TIMEOUT_ERR`=0. Pointers and the timeout counter are 0 and the FSM is in IDLE. Memory contents are don't-care.
- Reset asserted mid-operation: all entries are discarded and outputs return to their reset values immediately, without waiting for a clock edge.
- Latency when empty, idle, and `Busy`=0: with `WR_EN` sampled at edge k, `EMPTY` falls after edge k. `Data_Valid` and `P_DATA` update at edge k+1, so the strobe is high in the cycle after k+1. There is no fall-through path.
- `Data_Valid` is high for exactly one cycle per popped byte, and never while `Busy`=1 at the time of the issue decision.
- Issue gap: after `Busy` falls (sampled at edge m), the FSM returns to IDLE at edge m. The next issue occurs at edge m+1 if the FIFO is non-empty.
- `COUNT`, `FULL` and `EMPTY` reflect the state after each edge. `FULL` and `EMPTY` are never both 1.
- Pointer wrap: after 2**ADDR_WIDTH writes the write pointer returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset then idle: after `RST` is pulsed, `EMPTY`=1, `COUNT`=0, `Data_Valid`=0, `P_DATA`=0x00. No strobe appears for 10 cycles.
- Single byte: write 0xA5 with `Busy`=0. `Data_Valid` pulses for one cycle two edges after the write, with `P_DATA`=0xA5. Raise `Busy` for 20 cycles, then drop it; `EMPTY`=1 and no second strobe.
- Burst and ordering: write 0x01..0x08 back-to-back while `Busy` is held 1.
  - `FULL`=1 and `COUNT`=8.
  - A 9th write of 0xFF sets `OVERFLOW` and `COUNT` stays 8.
  - Emulate the TX with `Busy` rising 1 cycle after each strobe and falling 12 cycles later. Bytes are issued in the order 0x01..0x08, one strobe per `Busy` cycle.
- Simultaneous write and pop: with `COUNT`=3, apply `WR_EN` on the issue edge. `COUNT` stays 3 and byte order is preserved across the pointer wrap.
- Timeout: issue a byte and keep `Busy`=0. `TIMEOUT_ERR` sets 4 cycles later and the FSM returns to IDLE; the next byte issues one cycle after that. `OVF_CLR` clears the flag.
- Async reset mid-burst: assert `RST` between clock edges while in WAIT_DONE with `COUNT`=5. All outputs return to their reset values immediately, before the next edge.
